// File: rtl/addsub_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// addsub_arbiter_pkg
// Shared constants for the add/sub arbiter slice:
//   WIDTH        operand/result width of the shared datapath
//   FLAG_*       bit positions inside the {sign, ovfl, zero} flag triple
//   PORT_*       requester ids as carried on rsp_id
//   flag_t       3-bit flag triple type
// ---------------------------------------------------------------------------
package addsub_arbiter_pkg;

   localparam int WIDTH  = 16;

   localparam int FLAG_Z = 0;
   localparam int FLAG_V = 1;
   localparam int FLAG_N = 2;

   localparam logic PORT_ALU  = 1'b0;
   localparam logic PORT_ADDR = 1'b1;

   typedef logic [2:0] flag_t;

   // Assemble the flag triple so every producer uses the same bit order.
   function automatic flag_t pack_flags(input logic sign, input logic ovfl, input logic zero);
      flag_t f;
      f         = '0;
      f[FLAG_N] = sign;
      f[FLAG_V] = ovfl;
      f[FLAG_Z] = zero;
      return f;
   endfunction

endpackage

// File: rtl/addsub_16bit.sv
// ---------------------------------------------------------------------------
// addsub_16bit
// Purely combinational saturating 16-bit add/subtract.
//   a, b   in   operands (two's complement)
//   sub    in   1 = a - b, 0 = a + b
//   sum    out  saturated result (0x7FFF / 0x8000 on signed overflow)
//   flag   out  {sign, ovfl, zero}; sign and zero describe the saturated sum
// Built from four 4-bit carry-lookahead nibbles with a rippled group carry.
// ---------------------------------------------------------------------------
module addsub_16bit
   import addsub_arbiter_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH-1:0] sum,
   output logic [2:0]       flag
);

   localparam int NIBBLES = WIDTH / 4;

   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH-1:0]   gen;
   logic [WIDTH-1:0]   prop;
   logic [WIDTH-1:0]   bit_c;      // carry into each bit
   logic [WIDTH-1:0]   raw_sum;
   logic [NIBBLES-1:0] grp_g;
   logic [NIBBLES-1:0] grp_p;
   logic [NIBBLES:0]   nib_c;      // carry into each nibble, [NIBBLES] = carry out
   logic               ovfl;

   // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
   assign b_eff = b ^ {WIDTH{sub}};
   assign gen   = a & b_eff;
   assign prop  = a ^ b_eff;

   genvar gi;
   generate
      for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
         localparam int L = 4 * gi;
         logic       cin;
         logic [3:0] cb;

         // Group generate/propagate do not depend on the incoming carry.
         assign grp_p[gi] = &prop[L +: 4];
         assign grp_g[gi] = gen[L+3]
                          | (prop[L+3] & gen[L+2])
                          | (prop[L+3] & prop[L+2] & gen[L+1])
                          | (prop[L+3] & prop[L+2] & prop[L+1] & gen[L]);

         // Flattened lookahead: every internal carry derives from cin only.
         assign cin   = nib_c[gi];
         assign cb[0] = cin;
         assign cb[1] = gen[L] | (prop[L] & cin);
         assign cb[2] = gen[L+1] | (prop[L+1] & gen[L])
                      | (prop[L+1] & prop[L] & cin);
         assign cb[3] = gen[L+2] | (prop[L+2] & gen[L+1])
                      | (prop[L+2] & prop[L+1] & gen[L])
                      | (prop[L+2] & prop[L+1] & prop[L] & cin);

         assign bit_c[L +: 4]   = cb;
         assign raw_sum[L +: 4] = prop[L +: 4] ^ cb;
      end
   endgenerate

   always_comb begin
      nib_c[0] = sub;
      for (int i = 0; i < NIBBLES; i++) begin
         nib_c[i+1] = grp_g[i] | (grp_p[i] & nib_c[i]);
      end
   end

   // Signed overflow: carry into the MSB differs from carry out of it.
   assign ovfl = nib_c[NIBBLES] ^ bit_c[WIDTH-1];

   // On overflow the true result has the sign of a (both effective operands agree).
   always_comb begin
      sum = raw_sum;
      if (ovfl) begin
         sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end

   assign flag = pack_flags(sum[WIDTH-1], ovfl, (sum == '0));

endmodule

// File: rtl/addsub_arbiter.sv
// ---------------------------------------------------------------------------
// addsub_arbiter
// Two requesters share one saturating add/sub datapath through a round-robin
// arbiter and a two-stage registered pipeline.
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[1:0]        per-port request valid (bit 0 = ALU, bit 1 = ADDR)
//   req_ready[1:0]        combinational grant, at most one bit set
//   req_a0/b0/sub0        port-0 operands and op (sub: 1 = a-b)
//   req_a1/b1/sub1        port-1 operands and op
//   flush                 kills in-flight work, blocks accepts this cycle
//   rsp_valid             one-cycle pulse per completed request
//   rsp_id                owning port of the result
//   rsp_sum, rsp_flag     saturated result and {sign, ovfl, zero}
//   flag_q                architectural flags from the last port-0 result
// WIDTH is fixed at 16 by the shared datapath.
// ---------------------------------------------------------------------------
module addsub_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic             req_sub0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   input  logic             req_sub1,
   input  logic             flush,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_sum,
   output logic [2:0]       rsp_flag,
   output logic [2:0]       flag_q
);

   import addsub_arbiter_pkg::*;

   // Arbitration
   logic             last_grant_reg;
   logic             grant_id;
   logic             accept;

   // Stage 1
   logic             s1_valid_reg;
   logic [WIDTH-1:0] s1_a_reg;
   logic [WIDTH-1:0] s1_b_reg;
   logic             s1_sub_reg;
   logic             s1_id_reg;
   logic [WIDTH-1:0] s1_a_next;
   logic [WIDTH-1:0] s1_b_next;
   logic             s1_sub_next;

   // Datapath and stage 2
   logic [WIDTH-1:0] dp_sum;
   flag_t            dp_flag;
   logic             rsp_valid_reg;
   logic             rsp_id_reg;
   logic [WIDTH-1:0] rsp_sum_reg;
   flag_t            rsp_flag_reg;
   flag_t            flag_q_reg;

   // Round-robin grant: on contention the port that did not win last time
   // goes; last_grant resets to ADDR so ALU wins the first contest.
   always_comb begin
      grant_id = PORT_ALU;
      accept   = 1'b0;
      if (!flush) begin
         if (req_valid[0] && req_valid[1]) begin
            accept   = 1'b1;
            grant_id = ~last_grant_reg;
         end else if (req_valid[0]) begin
            accept   = 1'b1;
            grant_id = PORT_ALU;
         end else if (req_valid[1]) begin
            accept   = 1'b1;
            grant_id = PORT_ADDR;
         end
      end
   end

   always_comb begin
      req_ready = 2'b00;
      if (accept) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   always_comb begin
      s1_a_next   = req_a0;
      s1_b_next   = req_b0;
      s1_sub_next = req_sub0;
      if (grant_id == PORT_ADDR) begin
         s1_a_next   = req_a1;
         s1_b_next   = req_b1;
         s1_sub_next = req_sub1;
      end
   end

   addsub_16bit u_addsub (
      .a    (s1_a_reg),
      .b    (s1_b_reg),
      .sub  (s1_sub_reg),
      .sum  (dp_sum),
      .flag (dp_flag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_reg <= PORT_ADDR;
         s1_valid_reg   <= 1'b0;
         s1_a_reg       <= '0;
         s1_b_reg       <= '0;
         s1_sub_reg     <= 1'b0;
         s1_id_reg      <= PORT_ALU;
         rsp_valid_reg  <= 1'b0;
         rsp_id_reg     <= PORT_ALU;
         rsp_sum_reg    <= '0;
         rsp_flag_reg   <= '0;
         flag_q_reg     <= '0;
      end else begin
         // accept is already low during flush, so this also clears S1 on flush.
         s1_valid_reg <= accept;
         if (accept) begin
            last_grant_reg <= grant_id;
            s1_a_reg       <= s1_a_next;
            s1_b_reg       <= s1_b_next;
            s1_sub_reg     <= s1_sub_next;
            s1_id_reg      <= grant_id;
         end

         rsp_valid_reg <= s1_valid_reg & ~flush;
         if (s1_valid_reg) begin
            rsp_id_reg   <= s1_id_reg;
            rsp_sum_reg  <= dp_sum;
            rsp_flag_reg <= dp_flag;
         end

         // A flush in the same cycle still shows the S2 response but must
         // not commit it to the architectural flags.
         if (rsp_valid_reg && (rsp_id_reg == PORT_ALU) && !flush) begin
            flag_q_reg <= rsp_flag_reg;
         end
      end
   end

   assign rsp_valid = rsp_valid_reg;
   assign rsp_id    = rsp_id_reg;
   assign rsp_sum   = rsp_sum_reg;
   assign rsp_flag  = rsp_flag_reg;
   assign flag_q    = flag_q_reg;

endmodule

// File: tb/tb_addsub_arbiter.sv
// ---------------------------------------------------------------------------
// tb_addsub_arbiter
// Directed stimulus with hand-computed results. Each accepted request pushes
// its expected response into a scoreboard queue; an independent monitor pops
// and compares whenever rsp_valid is seen.
// ---------------------------------------------------------------------------
module tb_addsub_arbiter;

   typedef struct packed {
      logic        id;
      logic [15:0] sum;
      logic [2:0]  flag;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_a0, req_b0, req_a1, req_b1;
   logic        req_sub0, req_sub1;
   logic        flush;
   logic        rsp_valid;
   logic        rsp_id;
   logic [15:0] rsp_sum;
   logic [2:0]  rsp_flag;
   logic [2:0]  flag_q;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   addsub_arbiter #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_sub0  (req_sub0),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .req_sub1  (req_sub1),
      .flush     (flush),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_flag  (rsp_flag),
      .flag_q    (flag_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called just after a rising edge; leaves the time just after the next one.
   task automatic drive(input string tag, input logic [1:0] v, input logic fl,
                        input logic [15:0] a0, input logic [15:0] b0, input logic s0,
                        input logic [15:0] a1, input logic [15:0] b1, input logic s1,
                        input logic [1:0] exp_rdy, input logic push,
                        input logic [15:0] es0, input logic [2:0] ef0,
                        input logic [15:0] es1, input logic [2:0] ef1);
      exp_t e;
      req_valid = v;   flush    = fl;
      req_a0    = a0;  req_b0   = b0;  req_sub0 = s0;
      req_a1    = a1;  req_b1   = b1;  req_sub1 = s1;
      #3;
      $display("req %s valid=%b flush=%b ready=%b", tag, v, fl, req_ready);
      chk({tag, ".req_ready"}, 32'(req_ready), 32'(exp_rdy));
      if (push && exp_rdy[0]) begin
         e = '{id: 1'b0, sum: es0, flag: ef0};
         sb.push_back(e);
      end
      if (push && exp_rdy[1]) begin
         e = '{id: 1'b1, sum: es1, flag: ef1};
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         req_valid = 2'b00; flush = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compares every response against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            $display("rsp id=%0d sum=%h flag=%b", rsp_id, rsp_sum, rsp_flag);
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rsp: got id=%0d sum=%h expected no response", rsp_id, rsp_sum);
            end else begin
               e = sb.pop_front();
               chk("rsp_id",   32'(rsp_id),   32'(e.id));
               chk("rsp_sum",  32'(rsp_sum),  32'(e.sum));
               chk("rsp_flag", 32'(rsp_flag), 32'(e.flag));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; req_valid = 2'b00; flush = 1'b0;
      req_a0 = '0; req_b0 = '0; req_sub0 = 1'b0;
      req_a1 = '0; req_b1 = '0; req_sub1 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset.rsp_sum",   32'(rsp_sum),   32'd0);
      chk("reset.rsp_flag",  32'(rsp_flag),  32'd0);
      chk("reset.flag_q",    32'(flag_q),    32'd0);
      rst_n = 1'b1;
      idle(1);

      // Positive saturation on port 0, with exact latency checks.
      drive("pos_sat", 2'b01, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0,
            2'b01, 1'b1, 16'h7FFF, 3'b010, 16'h0, 3'b000);
      chk("pos_sat.s1_only", 32'(rsp_valid), 32'd0);
      idle(1);
      chk("pos_sat.rsp_valid", 32'(rsp_valid), 32'd1);
      chk("pos_sat.flag_q_before", 32'(flag_q), 32'd0);
      idle(1);
      chk("pos_sat.rsp_pulse", 32'(rsp_valid), 32'd0);
      chk("pos_sat.flag_q", 32'(flag_q), 32'b010);

      // Negative saturation on port 1 leaves flag_q alone.
      drive("neg_sat", 2'b10, 1'b0, 16'h0, 16'h0, 1'b0, 16'h8000, 16'h0001, 1'b1,
            2'b10, 1'b1, 16'h0, 3'b000, 16'h8000, 3'b110);
      idle(3);
      chk("neg_sat.flag_q", 32'(flag_q), 32'b010);

      // Zero result on port 0.
      drive("zero", 2'b01, 1'b0, 16'h0005, 16'h0005, 1'b1, 16'h0, 16'h0, 1'b0,
            2'b01, 1'b1, 16'h0000, 3'b001, 16'h0, 3'b000);
      idle(3);
      chk("zero.flag_q", 32'(flag_q), 32'b001);

      // Reset mid-stream: the in-flight request must vanish.
      drive("pre_reset", 2'b01, 1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0, 16'h0, 1'b0,
            2'b01, 1'b0, 16'h0, 3'b000, 16'h0, 3'b000);
      req_valid = 2'b00;
      rst_n = 1'b0;
      #2;
      chk("midreset.rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midreset.rsp_id",    32'(rsp_id),    32'd0);
      chk("midreset.rsp_sum",   32'(rsp_sum),   32'd0);
      chk("midreset.rsp_flag",  32'(rsp_flag),  32'd0);
      chk("midreset.flag_q",    32'(flag_q),    32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Contention from reset: grants 0,1,0,1; each port holds until granted.
      drive("cont0", 2'b11, 1'b0, 16'h1000, 16'h0234, 1'b0, 16'h0010, 16'h0020, 1'b1,
            2'b01, 1'b1, 16'h1234, 3'b000, 16'h0, 3'b000);
      drive("cont1", 2'b11, 1'b0, 16'h4000, 16'h4000, 1'b0, 16'h0010, 16'h0020, 1'b1,
            2'b10, 1'b1, 16'h0, 3'b000, 16'hFFF0, 3'b100);
      drive("cont2", 2'b11, 1'b0, 16'h4000, 16'h4000, 1'b0, 16'h0100, 16'h0100, 1'b1,
            2'b01, 1'b1, 16'h7FFF, 3'b010, 16'h0, 3'b000);
      drive("cont3", 2'b11, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0100, 16'h0100, 1'b1,
            2'b10, 1'b1, 16'h0, 3'b000, 16'h0000, 3'b001);
      idle(3);
      chk("cont.flag_q", 32'(flag_q), 32'b010);

      // Flush one cycle after a port-0 accept: no response, no accept.
      drive("flush_acc", 2'b01, 1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0,
            2'b01, 1'b0, 16'h0, 3'b000, 16'h0, 3'b000);
      drive("flush_cyc", 2'b10, 1'b1, 16'h0, 16'h0, 1'b0, 16'h0003, 16'h0001, 1'b0,
            2'b00, 1'b0, 16'h0, 3'b000, 16'h0, 3'b000);
      idle(3);
      chk("flush.flag_q", 32'(flag_q), 32'b010);

      // Flush while S2 holds a port-0 result: response shown, flag_q held.
      drive("s2_acc", 2'b01, 1'b0, 16'h0003, 16'h0003, 1'b1, 16'h0, 16'h0, 1'b0,
            2'b01, 1'b1, 16'h0000, 3'b001, 16'h0, 3'b000);
      idle(1);
      drive("s2_flush", 2'b00, 1'b1, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0,
            2'b00, 1'b0, 16'h0, 3'b000, 16'h0, 3'b000);
      idle(2);
      chk("s2_flush.flag_q", 32'(flag_q), 32'b010);

      // Last grant was port 0, so contention now goes to port 1.
      drive("post_flush", 2'b11, 1'b0, 16'h0009, 16'h0001, 1'b0, 16'h0007, 16'h0001, 1'b0,
            2'b10, 1'b1, 16'h0, 3'b000, 16'h0008, 3'b000);
      idle(4);
      chk("post_flush.flag_q", 32'(flag_q), 32'b010);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
